sakebi_eth_frame_tx: RTL and testbench
======================================

# sakebi_eth_frame_tx

Frame builder that sits directly upstream of `sakebi_rmii_tx` on the AXIS byte stream.
- Takes a raw payload frame (destination MAC through data, delimited by TLAST) and emits a gapless byte stream: 7×0x55 preamble, 0xD5 SFD, payload, optional zero pad to the minimum size, and 4-byte FCS.
- Then holds TVALID low for the inter-frame gap.
- The downstream RMII transmitter frames on TVALID alone, so output TVALID must stay continuously high from the first preamble byte to the last FCS byte.

## Interface
Parameters:
- PREAMBLE_LEN, 7, number of 0x55 bytes before SFD
- MIN_LEN, 60, minimum payload+pad bytes (excluding FCS)
- IFG_CYCLES, 12, ACLK cycles m_axis_TVALID is held low after the last FCS byte

Ports:
- i_axis_ACLK  in  1  the single clock; all logic on rising edge
- i_axis_ARESET  in  1  asynchronous, active-high reset
- i_s_axis_TVALID  in  1  payload byte valid
- o_s_axis_TREADY  out  1  payload byte accepted
- i_s_axis_TDATA  in  8  payload byte
- i_s_axis_TLAST  in  1  last payload byte of frame
- o_m_axis_TVALID  out  1  to sakebi_rmii_tx i_axis_TVALID
- i_m_axis_TREADY  in  1  from sakebi_rmii_tx o_axis_TREADY
- o_m_axis_TDATA  out  8  to sakebi_rmii_tx i_axis_TDATA
- o_err_underrun  out  1  one-cycle pulse: input ran dry mid-frame

## Operation
- **States:** IDLE, PRE, SFD, PAYLOAD, PAD, FCS, IFG, DROP.
- **IDLE → PRE:** on i_s_axis_TVALID=1. The byte is not consumed.
- **PRE:** emit 0x55 PREAMBLE_LEN times.
- **SFD:** emit 0xD5. Clear CRC to 0xFFFFFFFF.
- **PAYLOAD:**
  - o_s_axis_TREADY = (!o_m_axis_TVALID || i_m_axis_TREADY).
  - Each accepted byte is loaded to the output register, fed to the CRC, and counted (count saturates at MIN_LEN).
- **End of payload (TLAST accepted):**
  - Count < MIN_LEN → PAD, emitting 0x00 bytes (fed to CRC) until the count reaches MIN_LEN.
  - Otherwise → FCS.
- **FCS:** emit ~crc, byte 0 (bits 7:0) first, 4 bytes total. Then IFG.
- **IFG:**
  - o_m_axis_TVALID=0 for IFG_CYCLES cycles.
  - o_s_axis_TREADY=0 throughout.
  - Then IDLE.
- **CRC:** IEEE 802.3, reflected polynomial 0xEDB88320, init 0xFFFFFFFF, LSB-first, final complement.
- **Underrun:** i_s_axis_TVALID=0 in PAYLOAD while the output register is free.
  - Pulse o_err_underrun and drop o_m_axis_TVALID; downstream sees a truncated frame.
  - Enter DROP: TREADY=1, discard input through TLAST, then IFG.
- **Output register:** advances only when o_m_axis_TVALID && i_m_axis_TREADY. TDATA is stable while TVALID=1 and TREADY=0.
- **Reset (asynchronous, any state, including mid-frame):**
  - State → IDLE; counters and CRC cleared.
  - o_m_axis_TVALID=0, o_m_axis_TDATA=0x00, o_s_axis_TREADY=0, o_err_underrun=0.
  - No IFG is inserted after a reset.

## Timing
- First 0x55 on o_m_axis_TDATA with TVALID=1 one cycle after TVALID is seen in IDLE.
- Payload latency: accepted in cycle t → presented in cycle t+1.
- Total TVALID-high transfers per frame: PREAMBLE_LEN + 1 + max(N, MIN_LEN) + 4.
- TLAST on a 1-byte frame: handled like any frame (pads 59 bytes).
- TLAST accepted simultaneously with count reaching MIN_LEN: go straight to FCS, no PAD byte.
- i_m_axis_TREADY low in any emitting state: hold state, data, CRC and counters. This is not an underrun.
- IFG counter starts the cycle after the last FCS handshake.

## Configuration
- **SAKEBI_ETH_FRAME_PAD_EN:**
  - Defined: PAD state present; short frames padded to MIN_LEN.
  - Undefined: PAD state and length counter are compiled out; TLAST always proceeds directly to FCS, so short frames go out unpadded.

## Structure
- **Package `sakebi_eth_pkg`:**
  - Constants: ETH_PREAMBLE=8'h55, ETH_SFD=8'hD5, CRC32_POLY_REF=32'hEDB88320, CRC32_INIT=32'hFFFFFFFF, CRC32_RESIDUE=32'hDEBB20E3.
  - The state enum typedef.
- **Sub-module `sakebi_crc32_d8`:** combinational next-CRC from (crc[31:0], data[7:0]). Reused by the future RX FCS checker.

## Test plan
- **CRC sub-module:** feed ASCII "123456789" → complemented result 0xCBF43926.
- **Short frame:** 14-byte frame 0x33..0x40 with TLAST, TREADY tied 1 → 7×0x55, 0xD5, 14 bytes, 46×0x00, 4 FCS bytes; TVALID continuous for 72 cycles; re-running CRC over payload+pad+FCS leaves 0xDEBB20E3; then TVALID low ≥12 cycles.
- **Long frame:** 100 bytes → no pad, 112 transfers; FCS matches reference model.
- **Backpressure:** toggle i_m_axis_TREADY every other cycle on the 14-byte frame → identical byte sequence, TDATA stable while stalled, no o_err_underrun.
- **Underrun:** drop s_axis TVALID after byte 5 of 20 → o_err_underrun one pulse, TVALID falls; remaining bytes through TLAST consumed with no output; next frame starts cleanly after IFG.
- **Reset mid-frame:** assert reset during FCS byte 2 → all outputs zero immediately; next frame starts with full preamble one cycle after TVALID.

Source files
------------

// File: rtl/sakebi_eth_pkg.sv
// Shared Ethernet framing constants and the TX builder state encoding.
package sakebi_eth_pkg;
  localparam logic [7:0]  ETH_PREAMBLE   = 8'h55;
  localparam logic [7:0]  ETH_SFD        = 8'hD5;
  localparam logic [31:0] CRC32_POLY_REF = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT     = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE  = 32'hDEBB20E3;

  typedef enum logic [2:0] {
    ST_IDLE, ST_PRE, ST_SFD, ST_PAYLOAD, ST_PAD, ST_FCS, ST_IFG, ST_DROP
  } eth_tx_state_e;
endpackage

// File: rtl/sakebi_crc32_d8.sv
// Combinational IEEE 802.3 CRC-32 step over one byte, reflected, LSB first.
module sakebi_crc32_d8
  import sakebi_eth_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] crc_next
);
  always_comb begin
    crc_next = crc;
    for (int i = 0; i < 8; i++)
      crc_next = (crc_next >> 1) ^ (CRC32_POLY_REF & {32{crc_next[0] ^ data[i]}});
  end
endmodule

// File: rtl/sakebi_eth_frame_tx.sv
// Ethernet frame builder: preamble, SFD, payload, optional pad, FCS, then IFG.
// Padding to MIN_LEN is built only when SAKEBI_ETH_FRAME_PAD_EN is defined.
module sakebi_eth_frame_tx
  import sakebi_eth_pkg::*;
#(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_LEN      = 60,
  parameter int IFG_CYCLES   = 12
) (
  input  logic       i_axis_ACLK,
  input  logic       i_axis_ARESET,
  input  logic       i_s_axis_TVALID,
  output logic       o_s_axis_TREADY,
  input  logic [7:0] i_s_axis_TDATA,
  input  logic       i_s_axis_TLAST,
  output logic       o_m_axis_TVALID,
  input  logic       i_m_axis_TREADY,
  output logic [7:0] o_m_axis_TDATA,
  output logic       o_err_underrun
);
  localparam int CNT_MAX = (PREAMBLE_LEN > IFG_CYCLES) ? PREAMBLE_LEN :
                           ((IFG_CYCLES > 4) ? IFG_CYCLES : 4);
  localparam int CW = $clog2(CNT_MAX + 1);

  eth_tx_state_e state_q, state_d;
  logic          m_valid_q, m_valid_d, err_q, err_d, out_free;
  logic [7:0]    m_data_q, m_data_d, crc_din, fcs_byte;
  logic [31:0]   crc_q, crc_d, crc_next, crc_inv;
  logic [CW-1:0] cnt_q, cnt_d;

`ifdef SAKEBI_ETH_FRAME_PAD_EN
  localparam int LW = $clog2(MIN_LEN + 1);
  logic [LW-1:0] len_q, len_d, len_inc;
  assign len_inc = (len_q == LW'(MIN_LEN)) ? len_q : len_q + 1'b1;
`else
  // Without padding the minimum length has no effect.
  logic unused_min_len;
  assign unused_min_len = |MIN_LEN;
`endif

  // The output register may be reloaded when empty or being taken this cycle.
  assign out_free = !m_valid_q || i_m_axis_TREADY;
  assign crc_din  = (state_q == ST_PAD) ? 8'h00 : i_s_axis_TDATA;
  assign crc_inv  = ~crc_q;
  assign fcs_byte = crc_inv[{cnt_q[1:0], 3'b000} +: 8];

  sakebi_crc32_d8 u_crc (.crc(crc_q), .data(crc_din), .crc_next(crc_next));

  always_ff @(posedge i_axis_ACLK or posedge i_axis_ARESET) begin
    if (i_axis_ARESET) state_q <= ST_IDLE;
    else               state_q <= state_d;
  end

  always_ff @(posedge i_axis_ACLK or posedge i_axis_ARESET) begin
    if (i_axis_ARESET) begin
      m_valid_q <= 1'b0;
      m_data_q  <= 8'h00;
      crc_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
`ifdef SAKEBI_ETH_FRAME_PAD_EN
      len_q     <= '0;
`endif
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      crc_q     <= crc_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
`ifdef SAKEBI_ETH_FRAME_PAD_EN
      len_q     <= len_d;
`endif
    end
  end

  // State names the source of the next byte loaded into the output register.
  always_comb begin
    state_d         = state_q;
    m_valid_d       = m_valid_q;
    m_data_d        = m_data_q;
    crc_d           = crc_q;
    cnt_d           = cnt_q;
    err_d           = 1'b0;
    o_s_axis_TREADY = 1'b0;
`ifdef SAKEBI_ETH_FRAME_PAD_EN
    len_d           = len_q;
`endif
    case (state_q)
      ST_IDLE: if (i_s_axis_TVALID) begin
        m_valid_d = 1'b1;
        m_data_d  = ETH_PREAMBLE;
        cnt_d     = CW'(1);
        state_d   = (PREAMBLE_LEN > 1) ? ST_PRE : ST_SFD;
      end
      ST_PRE: if (out_free) begin
        m_data_d = ETH_PREAMBLE;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(PREAMBLE_LEN - 1)) state_d = ST_SFD;
      end
      ST_SFD: if (out_free) begin
        m_data_d = ETH_SFD;
        crc_d    = CRC32_INIT;
        state_d  = ST_PAYLOAD;
`ifdef SAKEBI_ETH_FRAME_PAD_EN
        len_d    = '0;
`endif
      end
      ST_PAYLOAD: begin
        o_s_axis_TREADY = out_free;
        if (out_free) begin
          if (i_s_axis_TVALID) begin
            m_data_d = i_s_axis_TDATA;
            crc_d    = crc_next;
            cnt_d    = '0;
`ifdef SAKEBI_ETH_FRAME_PAD_EN
            len_d    = len_inc;
            if (i_s_axis_TLAST) state_d = (len_inc < LW'(MIN_LEN)) ? ST_PAD : ST_FCS;
`else
            if (i_s_axis_TLAST) state_d = ST_FCS;
`endif
          end else begin
            // Source ran dry: truncate the frame rather than stretch it.
            m_valid_d = 1'b0;
            err_d     = 1'b1;
            state_d   = ST_DROP;
          end
        end
      end
`ifdef SAKEBI_ETH_FRAME_PAD_EN
      ST_PAD: if (out_free) begin
        m_data_d = 8'h00;
        crc_d    = crc_next;
        len_d    = len_inc;
        cnt_d    = '0;
        if (len_inc == LW'(MIN_LEN)) state_d = ST_FCS;
      end
`endif
      ST_FCS: if (out_free) begin
        if (cnt_q == CW'(4)) begin
          m_valid_d = 1'b0;
          cnt_d     = '0;
          state_d   = ST_IFG;
        end else begin
          m_data_d = fcs_byte;
          cnt_d    = cnt_q + 1'b1;
        end
      end
      ST_IFG: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(IFG_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      ST_DROP: begin
        o_s_axis_TREADY = 1'b1;
        if (i_s_axis_TVALID && i_s_axis_TLAST) begin
          cnt_d   = '0;
          state_d = ST_IFG;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_m_axis_TVALID = m_valid_q;
  assign o_m_axis_TDATA  = m_data_q;
  assign o_err_underrun  = err_q;
endmodule

// File: tb/tb_sakebi_eth_frame_tx.sv
// Directed scoreboard bench for sakebi_eth_frame_tx and its CRC step.
module tb_sakebi_eth_frame_tx;
  import sakebi_eth_pkg::*;
  localparam int PRE = 7, MINL = 60, IFG = 12;
`ifdef SAKEBI_ETH_FRAME_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  logic        clk = 1'b0, rst = 1'b1;
  logic        s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b1;
  logic        s_ready, m_valid, err;
  logic [7:0]  s_data = 8'h00, m_data;
  logic [31:0] c_in, c_out;
  logic [7:0]  c_d;
  logic [71:0] ascii;
  logic [31:0] c_acc;
  logic [7:0]  sb[$];
  int          tests = 0, fails = 0, gcyc = 0, last_fire = -1000;

  always #5 clk = ~clk;

  sakebi_eth_frame_tx #(.PREAMBLE_LEN(PRE), .MIN_LEN(MINL), .IFG_CYCLES(IFG)) dut (
    .i_axis_ACLK(clk), .i_axis_ARESET(rst),
    .i_s_axis_TVALID(s_valid), .o_s_axis_TREADY(s_ready),
    .i_s_axis_TDATA(s_data), .i_s_axis_TLAST(s_last),
    .o_m_axis_TVALID(m_valid), .i_m_axis_TREADY(m_ready),
    .o_m_axis_TDATA(m_data), .o_err_underrun(err)
  );

  sakebi_crc32_d8 u_crc (.crc(c_in), .data(c_d), .crc_next(c_out));

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r = c;
    for (int i = 0; i < 8; i++)
      if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    assert (act === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  // toggle: downstream ready alternates; stop_after: bytes sent before an underrun
  // (-1 none); rst_at: transfers completed before reset is forced (-1 none).
  task automatic run_frame(input string nm, input int n, input logic [7:0] base,
                           input logic [7:0] step, input bit toggle, input int stop_after,
                           input int rst_at, input bit chk_lat);
    logic [7:0]  pl[$];
    logic [7:0]  got[$];
    logic [7:0]  prev = 8'h00, exp;
    logic [31:0] mcrc = 32'hFFFFFFFF, res;
    int  sent = 0, hold = 0, fires = 0, gaps = 0, errs = 0, first = -1, start = gcyc;
    int  plen = (PAD_EN && n < MINL) ? MINL : n;
    bit  stall = 1'b0, done = 1'b0, uflow = (stop_after >= 0);
    for (int i = 0; i < n; i++) pl.push_back(base + 8'(i) * step);
    for (int i = 0; i < PRE; i++) sb.push_back(8'h55);
    sb.push_back(8'hD5);
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      m_ready = toggle ? gcyc[0] : 1'b1;
      if (sent < n && !(uflow && sent == stop_after && hold < 3)) begin
        s_valid = 1'b1; s_data = pl[sent]; s_last = (sent == n - 1);
      end else begin
        if (sent < n) hold++;
        s_valid = 1'b0; s_last = 1'b0;
      end
      @(negedge clk);
      if (rst_at >= 0 && fires == rst_at && m_valid) begin
        rst = 1'b1;
        #1;
        chk({nm, " rst tvalid"}, m_valid, 0);
        chk({nm, " rst tdata"}, m_data, 0);
        chk({nm, " rst s_tready"}, s_ready, 0);
        chk({nm, " rst err"}, err, 0);
        @(posedge clk); #1;
        rst = 1'b0; s_valid = 1'b0; s_last = 1'b0; gcyc++;
        sb.delete();
        return;
      end
      if (m_valid && first < 0) begin
        first = gcyc;
        if (chk_lat) chk({nm, " start latency"}, first - start, 1);
        else         chk({nm, " ifg >= IFG"}, (first - last_fire - 1) >= IFG, 1);
      end
      if (stall) begin
        chk({nm, " stall tvalid"}, m_valid, 1);
        chk({nm, " stall tdata"}, m_data, prev);
      end
      if (m_valid && m_ready) begin
        chk({nm, " expected byte pending"}, sb.size() > 0, 1);
        if (sb.size() > 0) begin
          exp = sb.pop_front();
          chk($sformatf("%s byte %0d", nm, fires), m_data, exp);
        end
        if (fires >= PRE + 1) got.push_back(m_data);
        fires++;
        last_fire = gcyc;
      end
      if (first >= 0 && !m_valid && sb.size() > 0 && !uflow) gaps++;
      if (err) errs++;
      stall = m_valid && !m_ready;
      prev  = m_data;
      if (s_valid && s_ready) begin
        if (!uflow || sent < stop_after) begin
          sb.push_back(pl[sent]);
          mcrc = crc_upd(mcrc, pl[sent]);
        end
        if (s_last && !uflow) begin
          for (int i = n; i < plen; i++) begin
            sb.push_back(8'h00);
            mcrc = crc_upd(mcrc, 8'h00);
          end
          for (int i = 0; i < 4; i++) sb.push_back(8'(~mcrc >> (8 * i)));
        end
        sent++;
      end
      if (sent == n && sb.size() == 0 && !m_valid) done = 1'b1;
      @(posedge clk); #1;
      gcyc++;
    end
    chk({nm, " finished in budget"}, done, 1);
    chk({nm, " transfers"}, fires, uflow ? PRE + 1 + stop_after : PRE + 1 + plen + 4);
    chk({nm, " underrun pulses"}, errs, uflow ? 1 : 0);
    if (!uflow) begin
      chk({nm, " tvalid gaps"}, gaps, 0);
      res = 32'hFFFFFFFF;
      foreach (got[i]) res = crc_upd(res, got[i]);
      chk({nm, " fcs residue"}, res, CRC32_RESIDUE);
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset tvalid", m_valid, 0);
    chk("reset tdata", m_data, 0);
    chk("reset s_tready", s_ready, 0);
    chk("reset err", err, 0);
    rst = 1'b0;

    ascii = "123456789";
    c_acc = 32'hFFFFFFFF;
    for (int i = 0; i < 9; i++) begin
      c_in = c_acc; c_d = ascii[8 * (8 - i) +: 8];
      #1;
      c_acc = c_out;
    end
    chk("crc32 check string", ~c_acc, 32'hCBF43926);

    @(posedge clk); #1;
    run_frame("short",  14, 8'h33, 8'd1, 1'b0, -1, -1, 1'b1);
    run_frame("long",  100, 8'h01, 8'd7, 1'b0, -1, -1, 1'b0);
    run_frame("bp",     14, 8'h33, 8'd1, 1'b1, -1, -1, 1'b0);
    run_frame("min",  MINL, 8'h80, 8'd3, 1'b0, -1, -1, 1'b0);
    run_frame("one",     1, 8'hA5, 8'd0, 1'b0, -1, -1, 1'b0);
    run_frame("uflow",  20, 8'h10, 8'd1, 1'b0,  5, -1, 1'b0);
    run_frame("after",  14, 8'h33, 8'd1, 1'b0, -1, -1, 1'b0);
    run_frame("rstmid", 14, 8'h33, 8'd1, 1'b0, -1,
              PRE + 1 + ((PAD_EN && 14 < MINL) ? MINL : 14) + 2, 1'b0);
    run_frame("post",   14, 8'h21, 8'd5, 1'b0, -1, -1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
